// File: rtl/array_alloc_pkg.sv
// Shared constants and FSM state encoding for the array allocator.
package array_alloc_pkg;

    localparam int MEMORY_ELEMENT_WIDTH = 12;
    localparam int N_ARRAYS             = 4;
    localparam int N_AREA               = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ACK   = 2'd2
    } state_t;

endpackage

// File: rtl/free_stack.sv
// LIFO of released array numbers, recycled by the allocator before new numbers are issued.
module free_stack #(
    parameter int W     = array_alloc_pkg::MEMORY_ELEMENT_WIDTH,
    parameter int DEPTH = array_alloc_pkg::N_ARRAYS
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] top,
    output logic [W-1:0] count,
    output logic         empty,
    output logic         full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [W-1:0] DEPTH_W = W'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  cnt;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign wr_idx = cnt[AW-1:0];
    assign rd_idx = AW'(cnt - 1'b1);
    assign empty  = (cnt == '0);
    assign full   = (cnt == DEPTH_W);
    assign count  = cnt;
    assign top    = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + 1'b1;
        end else if (pop && !empty) begin
            cnt <= cnt - 1'b1;
        end
    end

    // NOTE: storage is not reset; the count alone decides which entries are valid.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/array_allocator.sv
// Issues array numbers (freed ones first, LIFO) and tracks per-array sizes.
// Define ARRAY_ALLOCATOR_CLEAR_EN to zero an array's heap area before acknowledging its alloc.
module array_allocator #(
    parameter int MEMORY_ELEMENT_WIDTH = array_alloc_pkg::MEMORY_ELEMENT_WIDTH,
    parameter int N_ARRAYS             = array_alloc_pkg::N_ARRAYS,
    parameter int N_AREA               = array_alloc_pkg::N_AREA
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            alloc_req,
    output logic                            alloc_ack,
    output logic [MEMORY_ELEMENT_WIDTH-1:0] alloc_array,
    input  logic                            free_req,
    input  logic [MEMORY_ELEMENT_WIDTH-1:0] free_array,
    output logic                            free_ack,
    input  logic                            size_we,
    input  logic [MEMORY_ELEMENT_WIDTH-1:0] size_array,
    input  logic [MEMORY_ELEMENT_WIDTH-1:0] size_index,
    input  logic [MEMORY_ELEMENT_WIDTH-1:0] size_rd_array,
    output logic [MEMORY_ELEMENT_WIDTH-1:0] size_rd_data,
    output logic                            heap_we,
    output logic [MEMORY_ELEMENT_WIDTH-1:0] heap_addr,
    output logic [MEMORY_ELEMENT_WIDTH-1:0] heap_wdata,
    output logic [MEMORY_ELEMENT_WIDTH-1:0] allocs,
    output logic                            full,
    output logic                            error
);

    import array_alloc_pkg::*;

    localparam int W  = MEMORY_ELEMENT_WIDTH;
    localparam int AW = (N_ARRAYS > 1) ? $clog2(N_ARRAYS) : 1;
    localparam logic [W-1:0] N_ARRAYS_W = W'(N_ARRAYS);
    localparam logic [W-1:0] N_AREA_W   = W'(N_AREA);

    state_t       state;
    logic [W-1:0] size_tbl [N_ARRAYS];
    logic [W-1:0] st_top;
    logic [W-1:0] st_count;
    logic         st_empty;
    logic         st_full;
    logic         st_push;
    logic         st_pop;
    logic         free_ok;
    logic         size_err;
    logic         alloc_go;
    logic [W-1:0] new_array;
    logic [W-1:0] size_next;

    assign full       = (allocs == N_ARRAYS_W) && (st_count == '0);
    assign free_ok    = (free_array < allocs) && !st_full;
    assign new_array  = st_empty ? allocs : st_top;
    assign alloc_go   = (state == IDLE) && !free_req && alloc_req && !full;
    assign st_push    = (state == IDLE) && free_req && free_ok;
    assign st_pop     = alloc_go && !st_empty;
    assign size_err   = size_we && (size_array >= N_ARRAYS_W);
    assign size_next  = size_index + 1'b1;
    assign heap_wdata = '0;

    assign size_rd_data = (size_rd_array < N_ARRAYS_W) ? size_tbl[size_rd_array[AW-1:0]] : '0;

    free_stack #(
        .W     (W),
        .DEPTH (N_ARRAYS)
    ) u_free_stack (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (st_push),
        .push_data (free_array),
        .pop       (st_pop),
        .top       (st_top),
        .count     (st_count),
        .empty     (st_empty),
        .full      (st_full)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_ARRAYS; i++) size_tbl[i] <= '0;
        end else begin
            if (size_we && !size_err && (size_tbl[size_array[AW-1:0]] < size_next)) begin
                size_tbl[size_array[AW-1:0]] <= size_next;
            end
            // NOTE: the later non-blocking assignment wins, so a fresh alloc overrides a same-edge size write.
            if (alloc_go) begin
                size_tbl[new_array[AW-1:0]] <= '0;
            end
        end
    end

`ifdef ARRAY_ALLOCATOR_CLEAR_EN
    logic [W-1:0] clr_k;
`else
    assign heap_we   = 1'b0;
    assign heap_addr = alloc_array * N_AREA_W;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            allocs      <= '0;
            alloc_ack   <= 1'b0;
            alloc_array <= '0;
            free_ack    <= 1'b0;
            error       <= 1'b0;
`ifdef ARRAY_ALLOCATOR_CLEAR_EN
            heap_we     <= 1'b0;
            heap_addr   <= '0;
            clr_k       <= '0;
`endif
        end else begin
            alloc_ack <= 1'b0;
            free_ack  <= 1'b0;
            error     <= size_err;
            case (state)
                IDLE: begin
                    if (free_req) begin
                        state    <= ACK;
                        free_ack <= 1'b1;
                        if (!free_ok) error <= 1'b1;
                    end else if (alloc_req) begin
                        if (full) begin
                            state       <= ACK;
                            alloc_ack   <= 1'b1;
                            alloc_array <= '0;
                            error       <= 1'b1;
                        end else begin
                            alloc_array <= new_array;
                            if (st_empty) allocs <= allocs + 1'b1;
`ifdef ARRAY_ALLOCATOR_CLEAR_EN
                            state     <= CLEAR;
                            heap_we   <= 1'b1;
                            heap_addr <= new_array * N_AREA_W;
                            clr_k     <= '0;
`else
                            state     <= ACK;
                            alloc_ack <= 1'b1;
`endif
                        end
                    end
                end
`ifdef ARRAY_ALLOCATOR_CLEAR_EN
                CLEAR: begin
                    if (clr_k == N_AREA_W - 1'b1) begin
                        heap_we   <= 1'b0;
                        heap_addr <= '0;
                        alloc_ack <= 1'b1;
                        state     <= ACK;
                    end else begin
                        clr_k     <= clr_k + 1'b1;
                        heap_addr <= heap_addr + 1'b1;
                    end
                end
`endif
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_array_allocator.sv
// Directed bench for array_allocator: vector table plus hand-written multi-cycle sequences.
module tb_array_allocator;

    import array_alloc_pkg::*;

    localparam int W = MEMORY_ELEMENT_WIDTH;
`ifdef ARRAY_ALLOCATOR_CLEAR_EN
    localparam int ALLOC_LAT = N_AREA + 1;
`else
    localparam int ALLOC_LAT = 1;
`endif

    typedef enum {OP_ALLOC, OP_FREE, OP_SIZE} op_e;

    typedef struct {
        op_e          op;
        logic [W-1:0] arg;
        logic [W-1:0] idx;
        logic [W-1:0] exp_val;
        logic         exp_err;
        logic [W-1:0] exp_allocs;
        logic         exp_full;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         alloc_req;
    logic         alloc_ack;
    logic [W-1:0] alloc_array;
    logic         free_req;
    logic [W-1:0] free_array;
    logic         free_ack;
    logic         size_we;
    logic [W-1:0] size_array;
    logic [W-1:0] size_index;
    logic [W-1:0] size_rd_array;
    logic [W-1:0] size_rd_data;
    logic         heap_we;
    logic [W-1:0] heap_addr;
    logic [W-1:0] heap_wdata;
    logic [W-1:0] allocs;
    logic         full;
    logic         error;

    array_allocator dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .alloc_req     (alloc_req),
        .alloc_ack     (alloc_ack),
        .alloc_array   (alloc_array),
        .free_req      (free_req),
        .free_array    (free_array),
        .free_ack      (free_ack),
        .size_we       (size_we),
        .size_array    (size_array),
        .size_index    (size_index),
        .size_rd_array (size_rd_array),
        .size_rd_data  (size_rd_data),
        .heap_we       (heap_we),
        .heap_addr     (heap_addr),
        .heap_wdata    (heap_wdata),
        .allocs        (allocs),
        .full          (full),
        .error         (error)
    );

    always #5 clock = ~clock;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(op_e op, int arg, int idx, int val, bit err, int al, bit fl);
        vecs.push_back('{op, W'(arg), W'(idx), W'(val), err, W'(al), fl});
    endfunction

    // Holds alloc_req until alloc_ack (bounded); optionally drives a size write on the accept edge.
    task automatic do_alloc(input string tag, input logic [W-1:0] exp_array, input logic exp_err,
                            input int exp_lat, input bit with_size,
                            input logic [W-1:0] s_arr, input logic [W-1:0] s_idx);
        int cyc = 0;
        bit got = 1'b0;
        alloc_req = 1'b1;
        if (with_size) begin
            size_we = 1'b1; size_array = s_arr; size_index = s_idx;
        end
        while (!got && cyc < 20) begin
            @(posedge clock); #1;
            cyc++;
            if (cyc == 1) size_we = 1'b0;
            if (alloc_ack) begin
                got = 1'b1;
            end else begin
`ifdef ARRAY_ALLOCATOR_CLEAR_EN
                if (cyc <= N_AREA) begin
                    check({tag, " heap_we"}, heap_we, 1);
                    check({tag, " heap_addr"}, heap_addr, exp_array * N_AREA + cyc - 1);
                end
`endif
            end
        end
        alloc_req = 1'b0;
        check({tag, " alloc_ack seen"}, got, 1);
        check({tag, " alloc latency"}, cyc, exp_lat);
        check({tag, " alloc_array"}, alloc_array, exp_array);
        check({tag, " error"}, error, exp_err);
        check({tag, " heap_we at ack"}, heap_we, 0);
        @(posedge clock); #1;
        check({tag, " alloc_ack pulse"}, alloc_ack, 0);
    endtask

    task automatic do_free(input string tag, input logic [W-1:0] arr, input logic exp_err);
        int cyc = 0;
        bit got = 1'b0;
        free_array = arr;
        free_req   = 1'b1;
        while (!got && cyc < 20) begin
            @(posedge clock); #1;
            cyc++;
            if (free_ack) got = 1'b1;
        end
        free_req = 1'b0;
        check({tag, " free_ack seen"}, got, 1);
        check({tag, " free latency"}, cyc, 1);
        check({tag, " error"}, error, exp_err);
        @(posedge clock); #1;
        check({tag, " free_ack pulse"}, free_ack, 0);
    endtask

    initial begin
        vec_t  v;
        string tag;
        int    acks;

        reset_n = 1'b0; alloc_req = 1'b0; free_req = 1'b0; free_array = '0;
        size_we = 1'b0; size_array = '0; size_index = '0; size_rd_array = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset alloc_ack", alloc_ack, 0);
        check("reset free_ack", free_ack, 0);
        check("reset error", error, 0);
        check("reset allocs", allocs, 0);
        check("reset full", full, 0);
        check("reset heap_we", heap_we, 0);
        check("reset heap_addr", heap_addr, 0);
        check("reset alloc_array", alloc_array, 0);
        check("reset size_rd_data", size_rd_data, 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        //  op        arg idx val err allocs full
        add(OP_ALLOC, 0, 0, 0, 0, 1, 0);
        add(OP_ALLOC, 0, 0, 1, 0, 2, 0);
        add(OP_ALLOC, 0, 0, 2, 0, 3, 0);
        add(OP_ALLOC, 0, 0, 3, 0, 4, 1);
        add(OP_ALLOC, 0, 0, 0, 1, 4, 1);
        add(OP_FREE,  2, 0, 0, 0, 4, 0);
        add(OP_FREE,  0, 0, 0, 0, 4, 0);
        add(OP_ALLOC, 0, 0, 0, 0, 4, 0);
        add(OP_ALLOC, 0, 0, 2, 0, 4, 1);
        add(OP_FREE,  9, 0, 0, 1, 4, 1);
        add(OP_FREE,  1, 0, 0, 0, 4, 0);
        add(OP_ALLOC, 0, 0, 1, 0, 4, 1);
        add(OP_SIZE,  1, 2, 3, 0, 4, 1);
        add(OP_SIZE,  1, 0, 3, 0, 4, 1);
        add(OP_SIZE,  1, 5, 6, 0, 4, 1);
        add(OP_SIZE,  4, 0, 0, 1, 4, 1);
        add(OP_SIZE,  3, 0, 1, 0, 4, 1);
        add(OP_FREE,  0, 0, 0, 0, 4, 0);
        add(OP_FREE,  1, 0, 0, 0, 4, 0);
        add(OP_FREE,  2, 0, 0, 0, 4, 0);
        add(OP_FREE,  3, 0, 0, 0, 4, 0);
        add(OP_FREE,  1, 0, 0, 1, 4, 0);
        add(OP_ALLOC, 0, 0, 3, 0, 4, 0);
        add(OP_SIZE,  2, 1, 2, 0, 4, 0);

        foreach (vecs[i]) begin
            v   = vecs[i];
            tag = $sformatf("v%0d", i);
            case (v.op)
                OP_ALLOC: begin
                    do_alloc(tag, v.exp_val, v.exp_err, v.exp_err ? 1 : ALLOC_LAT, 1'b0, '0, '0);
                    if (!v.exp_err) begin
                        size_rd_array = v.exp_val; #1;
                        check({tag, " size after alloc"}, size_rd_data, 0);
                    end
                end
                OP_FREE: do_free(tag, v.arg, v.exp_err);
                default: begin
                    size_we = 1'b1; size_array = v.arg; size_index = v.idx;
                    @(posedge clock); #1;
                    size_we = 1'b0;
                    check({tag, " size error"}, error, v.exp_err);
                    size_rd_array = v.arg; #1;
                    check({tag, " size_rd_data"}, size_rd_data, v.exp_val);
                end
            endcase
            check({tag, " allocs"}, allocs, v.exp_allocs);
            check({tag, " full"}, full, v.exp_full);
        end

        // Alloc popping array 2 while a size write to array 2 lands on the same edge.
        do_alloc("same-edge", 12'd2, 1'b0, ALLOC_LAT, 1'b1, 12'd2, 12'd4);
        size_rd_array = 12'd2; #1;
        check("same-edge size", size_rd_data, 0);

        // Free and alloc raised together: free first, alloc afterwards gets the freed number.
        free_array = 12'd2; free_req = 1'b1; alloc_req = 1'b1;
        @(posedge clock); #1;
        check("prio free_ack", free_ack, 1);
        check("prio alloc_ack", alloc_ack, 0);
        free_req = 1'b0;
        @(posedge clock); #1;
        check("prio alloc_ack idle", alloc_ack, 0);
        do_alloc("prio alloc", 12'd2, 1'b0, ALLOC_LAT, 1'b0, '0, '0);

        // Asynchronous reset between edges clears everything immediately.
        reset_n = 1'b0; #1;
        size_rd_array = 12'd1; #1;
        check("mid reset allocs", allocs, 0);
        check("mid reset full", full, 0);
        check("mid reset size", size_rd_data, 0);
        check("mid reset alloc_array", alloc_array, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        do_alloc("post reset", 12'd0, 1'b0, ALLOC_LAT, 1'b0, '0, '0);
        check("post reset allocs", allocs, 1);

`ifdef ARRAY_ALLOCATOR_CLEAR_EN
        // Reset in the third clear cycle of array 1 aborts the clear and the ack.
        alloc_req = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("abort heap_we before", heap_we, 1);
        check("abort heap_addr before", heap_addr, 9);
        reset_n = 1'b0; #1;
        alloc_req = 1'b0;
        check("abort heap_we", heap_we, 0);
        check("abort allocs", allocs, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        acks = 0;
        repeat (12) begin
            @(posedge clock); #1;
            if (alloc_ack || heap_we) acks++;
        end
        check("abort no ack", acks, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
